// File: rtl/pipe_controller.sv
`timescale 1ns/1ps
// pipe_controller: RV32I control decoder for the 5-stage core. It also carries the control fields through the D/E, E/M and M/W registers. RV32M decode is added when PIPE_CTRL_MEXT_EN is defined.
// Latency: ImmSrcD/IllegalD are combinational. E, M and W controls appear 1, 2 and 3 clocks after Decode.
// Backpressure: none. There is no stall input; FlushE/FlushM load a NOP bundle into the D/E and E/M registers.
module pipe_controller #(
   parameter int ALUCTRL_W = 4,
   parameter int RESULT_W  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           opD,
   input  logic [2:0]           funct3D,
   input  logic                 funct7b5D,
`ifdef PIPE_CTRL_MEXT_EN
   input  logic                 funct7b0D,
`endif
   input  logic                 ZeroE,
   input  logic                 LtE,
   input  logic                 LtuE,
   input  logic                 FlushE,
   input  logic                 FlushM,
   output logic [2:0]           ImmSrcD,
   output logic                 IllegalD,
   output logic                 ALUSrcE,
   output logic [ALUCTRL_W-1:0] ALUControlE,
   output logic                 PCSrcE,
   output logic                 PCTargetSrcE,
   output logic                 ResultSrcE0,
   output logic                 RegWriteM,
   output logic                 MemWriteM,
   output logic [2:0]           Funct3M,
   output logic                 RegWriteW,
`ifdef PIPE_CTRL_MEXT_EN
   output logic                 MulDivE,
`endif
   output logic [RESULT_W-1:0]  ResultSrcW
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_SLT   = 4'b0100;
   localparam logic [3:0] ALU_SLTU  = 4'b0101;
   localparam logic [3:0] ALU_XOR   = 4'b0110;
   localparam logic [3:0] ALU_SLL   = 4'b0111;
   localparam logic [3:0] ALU_SRL   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;
`ifdef PIPE_CTRL_MEXT_EN
   localparam logic [3:0] ALU_MUL   = 4'b1011;
   localparam logic [3:0] ALU_MULH  = 4'b1100;
   localparam logic [3:0] ALU_DIV   = 4'b1101;
   localparam logic [3:0] ALU_REM   = 4'b1110;
`endif

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNC  = 2'b10;
   localparam logic [1:0] ALUOP_PASSB = 2'b11;

   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef struct packed {
      logic                 regwrite;
      logic [RESULT_W-1:0]  resultsrc;
      logic                 memwrite;
      logic                 branch;
      logic                 jump;
      logic                 alusrc;
      logic                 pctargetsrc;
`ifdef PIPE_CTRL_MEXT_EN
      logic                 muldiv;
`endif
      logic [ALUCTRL_W-1:0] aluctrl;
      logic [2:0]           funct3;
   } de_t;

   typedef struct packed {
      logic                 regwrite;
      logic [RESULT_W-1:0]  resultsrc;
      logic                 memwrite;
      logic [2:0]           funct3;
   } em_t;

   typedef struct packed {
      logic                 regwrite;
      logic [RESULT_W-1:0]  resultsrc;
   } mw_t;

   de_t        dec;
   de_t        de_q;
   em_t        em_q;
   mw_t        mw_q;
   logic [2:0] imm_src;
   logic       illegal;
   logic [1:0] aluop;
   logic [3:0] func_code;
   logic [3:0] alu_code;
   logic       is_rtype;
   logic       is_muldiv;
   logic       cond;

   assign is_rtype = (opD == OP_RTYPE);

`ifdef PIPE_CTRL_MEXT_EN
   assign is_muldiv = is_rtype && funct7b0D && !funct7b5D;
`else
   assign is_muldiv = 1'b0;
`endif

   // funct7b5 only selects sub for R-type; for I-type it is an immediate bit except on srai
   always_comb begin
      func_code = ALU_ADD;
      case (funct3D)
         3'b000:  func_code = (is_rtype && funct7b5D) ? ALU_SUB : ALU_ADD;
         3'b001:  func_code = ALU_SLL;
         3'b010:  func_code = ALU_SLT;
         3'b011:  func_code = ALU_SLTU;
         3'b100:  func_code = ALU_XOR;
         3'b101:  func_code = funct7b5D ? ALU_SRA : ALU_SRL;
         3'b110:  func_code = ALU_OR;
         default: func_code = ALU_AND;
      endcase
`ifdef PIPE_CTRL_MEXT_EN
      if (is_muldiv) begin
         case (funct3D[2:1])
            2'b00:   func_code = funct3D[0] ? ALU_MULH : ALU_MUL;
            2'b01:   func_code = ALU_MULH;
            2'b10:   func_code = ALU_DIV;
            default: func_code = ALU_REM;
         endcase
      end
`endif
   end

   always_comb begin
      alu_code = ALU_ADD;
      case (aluop)
         ALUOP_SUB:   alu_code = ALU_SUB;
         ALUOP_FUNC:  alu_code = func_code;
         ALUOP_PASSB: alu_code = ALU_PASSB;
         default:     alu_code = ALU_ADD;
      endcase
   end

   // Illegal encodings leave every field at zero, so they travel down the pipe as a NOP
   always_comb begin
      dec     = '0;
      imm_src = IMM_I;
      illegal = 1'b0;
      aluop   = ALUOP_ADD;
      case (opD)
         OP_LOAD: begin
            dec.regwrite  = 1'b1;
            dec.alusrc    = 1'b1;
            dec.resultsrc = RESULT_W'(RES_MEM);
         end
         OP_STORE: begin
            imm_src      = IMM_S;
            dec.alusrc   = 1'b1;
            dec.memwrite = 1'b1;
         end
         OP_RTYPE: begin
            dec.regwrite = 1'b1;
            aluop        = ALUOP_FUNC;
         end
         OP_ITYPE: begin
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            aluop        = ALUOP_FUNC;
         end
         OP_BRANCH: begin
            if (funct3D[2:1] == 2'b01) begin
               illegal = 1'b1;
            end else begin
               imm_src    = IMM_B;
               dec.branch = 1'b1;
               aluop      = ALUOP_SUB;
            end
         end
         OP_JAL: begin
            imm_src       = IMM_J;
            dec.regwrite  = 1'b1;
            dec.jump      = 1'b1;
            dec.resultsrc = RESULT_W'(RES_PC4);
         end
         OP_JALR: begin
            if (funct3D != 3'b000) begin
               illegal = 1'b1;
            end else begin
               dec.regwrite    = 1'b1;
               dec.alusrc      = 1'b1;
               dec.jump        = 1'b1;
               dec.pctargetsrc = 1'b1;
               dec.resultsrc   = RESULT_W'(RES_PC4);
            end
         end
         OP_LUI: begin
            imm_src      = IMM_U;
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            aluop        = ALUOP_PASSB;
         end
         default: illegal = 1'b1;
      endcase
      if (!illegal) begin
         dec.aluctrl = ALUCTRL_W'(alu_code);
         dec.funct3  = funct3D;
`ifdef PIPE_CTRL_MEXT_EN
         dec.muldiv  = is_muldiv;
`endif
      end
   end

   assign ImmSrcD  = imm_src;
   assign IllegalD = illegal;

   always_ff @(posedge clk) begin
      if (reset || FlushE)
         de_q <= '0;
      else
         de_q <= dec;
   end

   always_ff @(posedge clk) begin
      if (reset || FlushM) begin
         em_q <= '0;
      end else begin
         em_q.regwrite  <= de_q.regwrite;
         em_q.resultsrc <= de_q.resultsrc;
         em_q.memwrite  <= de_q.memwrite;
         em_q.funct3    <= de_q.funct3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mw_q <= '0;
      end else begin
         mw_q.regwrite  <= em_q.regwrite;
         mw_q.resultsrc <= em_q.resultsrc;
      end
   end

   always_comb begin
      cond = 1'b0;
      case (de_q.funct3)
         3'b000:  cond = ZeroE;
         3'b001:  cond = !ZeroE;
         3'b100:  cond = LtE;
         3'b101:  cond = !LtE;
         3'b110:  cond = LtuE;
         3'b111:  cond = !LtuE;
         default: cond = 1'b0;
      endcase
   end

   assign PCSrcE       = (de_q.branch & cond) | de_q.jump;
   assign ALUSrcE      = de_q.alusrc;
   assign ALUControlE  = de_q.aluctrl;
   assign PCTargetSrcE = de_q.pctargetsrc;
   assign ResultSrcE0  = de_q.resultsrc[0];
   assign RegWriteM    = em_q.regwrite;
   assign MemWriteM    = em_q.memwrite;
   assign Funct3M      = em_q.funct3;
   assign RegWriteW    = mw_q.regwrite;
   assign ResultSrcW   = mw_q.resultsrc;
`ifdef PIPE_CTRL_MEXT_EN
   assign MulDivE      = de_q.muldiv;
`endif

endmodule

// File: tb/tb_pipe_controller.sv
`timescale 1ns/1ps
// tb_pipe_controller: decode vector table, hand-written pipeline/flush sequences, and random stimulus against a reference model.
module tb_pipe_controller;

   logic       clk = 1'b0;
   logic       reset, funct7b5D, ZeroE, LtE, LtuE, FlushE, FlushM;
   logic [6:0] opD;
   logic [2:0] funct3D;
   logic [2:0] ImmSrcD, Funct3M;
   logic       IllegalD, ALUSrcE, PCSrcE, PCTargetSrcE, ResultSrcE0;
   logic       RegWriteM, MemWriteM, RegWriteW;
   logic [3:0] ALUControlE;
   logic [1:0] ResultSrcW;
`ifdef PIPE_CTRL_MEXT_EN
   logic       funct7b0D = 1'b0;
   logic       MulDivE;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_controller dut (
      .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
`ifdef PIPE_CTRL_MEXT_EN
      .funct7b0D(funct7b0D), .MulDivE(MulDivE),
`endif
      .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .FlushE(FlushE), .FlushM(FlushM),
      .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
      .PCSrcE(PCSrcE), .PCTargetSrcE(PCTargetSrcE), .ResultSrcE0(ResultSrcE0),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
   );

   // Reference model: one decoded control record per instruction, shifted through E/M/W
   typedef struct packed {
      logic [2:0] imm;
      logic       ill, rw, mw, br, jmp, asrc, pcts;
      logic [1:0] rsrc;
      logic [3:0] alu;
      logic [2:0] f3;
   } ctl_t;

   ctl_t e_s, m_s, w_s;

   function automatic ctl_t spec_decode(input logic [6:0] op, input logic [2:0] f3, input logic b5);
      ctl_t        c;
      logic [31:0] tab;
      logic [3:0]  fn;
      c   = '0;
      tab = 32'h2386_5470;   // funct3 -> add,sll,slt,sltu,xor,srl,or,and
      fn  = tab[f3*4 +: 4];
      if (b5 && f3 == 3'd5) fn = 4'h9;
      case (op)
         7'b0000011: begin c.rw = 1'b1; c.asrc = 1'b1; c.rsrc = 2'd1; end
         7'b0100011: begin c.imm = 3'd1; c.asrc = 1'b1; c.mw = 1'b1; end
         7'b0110011: begin c.rw = 1'b1; c.alu = (f3 == 3'd0 && b5) ? 4'h1 : fn; end
         7'b0010011: begin c.rw = 1'b1; c.asrc = 1'b1; c.alu = fn; end
         7'b1100011: begin
            if (f3 == 3'd2 || f3 == 3'd3) c.ill = 1'b1;
            else begin c.imm = 3'd2; c.br = 1'b1; c.alu = 4'h1; end
         end
         7'b1101111: begin c.rw = 1'b1; c.imm = 3'd3; c.rsrc = 2'd2; c.jmp = 1'b1; end
         7'b1100111: begin
            if (f3 != 3'd0) c.ill = 1'b1;
            else begin c.rw = 1'b1; c.asrc = 1'b1; c.rsrc = 2'd2; c.jmp = 1'b1; c.pcts = 1'b1; end
         end
         7'b0110111: begin c.rw = 1'b1; c.imm = 3'd4; c.asrc = 1'b1; c.alu = 4'hA; end
         default:    c.ill = 1'b1;
      endcase
      if (!c.ill) c.f3 = f3;
      return c;
   endfunction

   function automatic logic taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
      logic base;
      base = f3[2] ? (f3[1] ? ltu : lt) : z;
      return (f3[2:1] == 2'b01) ? 1'b0 : (base ^ f3[0]);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock and update the model with the inputs present at that edge
   task automatic tick();
      ctl_t d;
      d = spec_decode(opD, funct3D, funct7b5D);
      @(posedge clk);
      if (reset) begin
         e_s = '0; m_s = '0; w_s = '0;
      end else begin
         w_s = m_s;
         m_s = FlushM ? '0 : e_s;
         e_s = FlushE ? '0 : d;
      end
      #1;
   endtask

   task automatic check_all(input int cyc);
      ctl_t d;
      d = spec_decode(opD, funct3D, funct7b5D);
      chk($sformatf("rnd%0d ImmSrcD", cyc), 32'(ImmSrcD), 32'(d.imm));
      chk($sformatf("rnd%0d IllegalD", cyc), 32'(IllegalD), 32'(d.ill));
      chk($sformatf("rnd%0d ALUSrcE", cyc), 32'(ALUSrcE), 32'(e_s.asrc));
      chk($sformatf("rnd%0d ALUControlE", cyc), 32'(ALUControlE), 32'(e_s.alu));
      chk($sformatf("rnd%0d PCSrcE", cyc), 32'(PCSrcE),
          32'((e_s.br & taken(e_s.f3, ZeroE, LtE, LtuE)) | e_s.jmp));
      chk($sformatf("rnd%0d PCTargetSrcE", cyc), 32'(PCTargetSrcE), 32'(e_s.pcts));
      chk($sformatf("rnd%0d ResultSrcE0", cyc), 32'(ResultSrcE0), 32'(e_s.rsrc[0]));
      chk($sformatf("rnd%0d RegWriteM", cyc), 32'(RegWriteM), 32'(m_s.rw));
      chk($sformatf("rnd%0d MemWriteM", cyc), 32'(MemWriteM), 32'(m_s.mw));
      chk($sformatf("rnd%0d Funct3M", cyc), 32'(Funct3M), 32'(m_s.f3));
      chk($sformatf("rnd%0d RegWriteW", cyc), 32'(RegWriteW), 32'(w_s.rw));
      chk($sformatf("rnd%0d ResultSrcW", cyc), 32'(ResultSrcW), 32'(w_s.rsrc));
   endtask

   typedef struct packed {
      logic [6:0] op;
      logic [2:0] f3;
      logic       b5, z, lt, ltu;
      logic [2:0] imm;
      logic       ill;
      logic [3:0] alu;
      logic       asrc, pcs, pcts, rs0;
   } vec_t;

   vec_t vt[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [6:0] ops[10];
      // op, f3, b5, z, lt, ltu | imm, ill, alu, asrc, pcs, pcts, rs0
      vt.push_back('{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1});
      vt.push_back('{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0110011, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0110011, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0110011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0110011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0010011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0010011, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0});
      vt.push_back('{7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b1100011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0});
      vt.push_back('{7'b1100011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0});
      vt.push_back('{7'b1100011, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b1100011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0});
      vt.push_back('{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0});
      vt.push_back('{7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0});
      vt.push_back('{7'b1100111, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0110111, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b0000000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
      vt.push_back('{7'b1110011, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});

      e_s = '0; m_s = '0; w_s = '0;
      reset = 1'b1; FlushE = 1'b0; FlushM = 1'b0;
      opD = 7'b0110011; funct3D = 3'b000; funct7b5D = 1'b0;
      ZeroE = 1'b1; LtE = 1'b1; LtuE = 1'b1;

      // Reset held with an R-type in Decode
      repeat (3) tick();
      chk("rst ALUControlE", 32'(ALUControlE), 0);
      chk("rst PCSrcE", 32'(PCSrcE), 0);
      chk("rst RegWriteM", 32'(RegWriteM), 0);
      chk("rst RegWriteW", 32'(RegWriteW), 0);
      chk("rst ResultSrcW", 32'(ResultSrcW), 0);
      chk("rst Funct3M", 32'(Funct3M), 0);
      reset = 1'b0;
      tick();
      chk("rel+1 ALUControlE", 32'(ALUControlE), 0);
      chk("rel+1 RegWriteW", 32'(RegWriteW), 0);
      tick();
      chk("rel+2 RegWriteM", 32'(RegWriteM), 1);
      chk("rel+2 RegWriteW", 32'(RegWriteW), 0);
      tick();
      chk("rel+3 RegWriteW", 32'(RegWriteW), 1);

      // Decode vector table
      for (int i = 0; i < vt.size(); i++) begin
         opD = vt[i].op; funct3D = vt[i].f3; funct7b5D = vt[i].b5;
         #1;
         chk($sformatf("vec%0d ImmSrcD", i), 32'(ImmSrcD), 32'(vt[i].imm));
         chk($sformatf("vec%0d IllegalD", i), 32'(IllegalD), 32'(vt[i].ill));
         tick();
         ZeroE = vt[i].z; LtE = vt[i].lt; LtuE = vt[i].ltu;
         #1;
         chk($sformatf("vec%0d ALUControlE", i), 32'(ALUControlE), 32'(vt[i].alu));
         chk($sformatf("vec%0d ALUSrcE", i), 32'(ALUSrcE), 32'(vt[i].asrc));
         chk($sformatf("vec%0d PCSrcE", i), 32'(PCSrcE), 32'(vt[i].pcs));
         chk($sformatf("vec%0d PCTargetSrcE", i), 32'(PCTargetSrcE), 32'(vt[i].pcts));
         chk($sformatf("vec%0d ResultSrcE0", i), 32'(ResultSrcE0), 32'(vt[i].rs0));
      end

      // lw through the pipe, followed by an R-type
      opD = 7'b0000011; funct3D = 3'b010; funct7b5D = 1'b0;
      tick();
      opD = 7'b0110011; funct3D = 3'b000;
      chk("lw E ResultSrcE0", 32'(ResultSrcE0), 1);
      tick();
      chk("lw M RegWriteM", 32'(RegWriteM), 1);
      chk("lw M Funct3M", 32'(Funct3M), 2);
      tick();
      chk("lw W ResultSrcW", 32'(ResultSrcW), 1);

      // jalr link result reaches W as PC+4
      opD = 7'b1100111; funct3D = 3'b000;
      tick();
      opD = 7'b0000000;
      tick(); tick();
      chk("jalr W ResultSrcW", 32'(ResultSrcW), 2);

      // sw with and without FlushE / FlushM
      opD = 7'b0100011; funct3D = 3'b010;
      tick();
      opD = 7'b0000000;
      tick();
      chk("sw noflush MemWriteM", 32'(MemWriteM), 1);
      opD = 7'b0100011; FlushE = 1'b1;
      tick();
      FlushE = 1'b0; opD = 7'b0000000;
      tick();
      chk("sw FlushE MemWriteM", 32'(MemWriteM), 0);
      opD = 7'b0100011;
      tick();
      FlushM = 1'b1; opD = 7'b0000000;
      tick();
      FlushM = 1'b0;
      chk("sw FlushM MemWriteM", 32'(MemWriteM), 0);

      // Both flushes together: E and M bubble, W still takes the old M (lw)
      opD = 7'b0000011; funct3D = 3'b010;
      tick();
      opD = 7'b0110011; funct3D = 3'b000;
      tick();
      opD = 7'b0100011; funct3D = 3'b010; FlushE = 1'b1; FlushM = 1'b1;
      tick();
      FlushE = 1'b0; FlushM = 1'b0; opD = 7'b0000000;
      chk("dflush ALUSrcE", 32'(ALUSrcE), 0);
      chk("dflush RegWriteM", 32'(RegWriteM), 0);
      chk("dflush Funct3M", 32'(Funct3M), 0);
      chk("dflush RegWriteW", 32'(RegWriteW), 1);
      chk("dflush ResultSrcW", 32'(ResultSrcW), 1);
      tick();
      chk("dflush+1 RegWriteW", 32'(RegWriteW), 0);
      chk("dflush+1 ResultSrcW", 32'(ResultSrcW), 0);

      // Randomized stimulus against the reference model
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0000000, 7'b1110011};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if ($urandom_range(0, 15) == 0) opD = 7'($urandom);
         else opD = ops[$urandom_range(0, 9)];
         funct3D   = 3'($urandom);
         funct7b5D = 1'($urandom);
         ZeroE     = 1'($urandom);
         LtE       = 1'($urandom);
         LtuE      = 1'($urandom);
         FlushE    = ($urandom_range(0, 7) == 0);
         FlushM    = ($urandom_range(0, 7) == 0);
         reset     = ($urandom_range(0, 49) == 0);
         #1;
         check_all(cyc);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
- Next-generation decoder for the 5-stage RISC-V pipeline core.
- Decodes the instruction in Decode and carries control fields through D/E, E/M and M/W pipeline registers.
- Supports flush of the E and M stage registers.
- Adds full branch-condition evaluation (beq/bne/blt/bge/bltu/bgeu), jalr, lui, a widened ALU control word, and illegal-opcode detection.
- Sits beside the datapath; the hazard unit drives its flushes and consumes ResultSrcE0 and RegWrite*.

Parameters:
ALUCTRL_W, 4, width of ALUControlE; legal values ≥4, extra MSBs driven 0.
RESULT_W, 2, width of ResultSrc fields; legal values ≥2.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; clears all pipeline registers
opD  in  7  instr[6:0] in Decode
funct3D  in  3  instr[14:12]
funct7b5D  in  1  instr[30]
ZeroE  in  1  ALU result == 0
LtE  in  1  signed rs1 < rs2
LtuE  in  1  unsigned rs1 < rs2
FlushE  in  1  bubble the D/E register
FlushM  in  1  bubble the E/M register
ImmSrcD  out  3  immediate type, combinational: 000 I, 001 S, 010 B, 011 J, 100 U
IllegalD  out  1  combinational: unsupported opcode/funct3 in Decode
ALUSrcE  out  1  1 = ALU operand B is the immediate
ALUControlE  out  ALUCTRL_W  ALU operation
PCSrcE  out  1  redirect fetch (taken branch or jump), combinational from E regs and flags
PCTargetSrcE  out  1  0 = PC+imm, 1 = rs1+imm (jalr)
ResultSrcE0  out  1  ResultSrcE[0], load-use detection
RegWriteM  out  1  registered
MemWriteM  out  1  registered
Funct3M  out  3  load/store size, registered
RegWriteW  out  1  registered
ResultSrcW  out  RESULT_W  00 ALU, 01 memory, 10 PC+4

Behaviour:
- Decode is combinational on the D inputs. Each field advances one stage per clock: D→E→M→W, 1 cycle per stage, no stall input. Upstream freezes are handled by the F/D register.
- Opcode map (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp):
  - 0000011 lw: 1, I, 1, 0, 01, 0, 0, add
  - 0100011 sw: 0, S, 1, 1, xx→00, 0, 0, add
  - 0110011 R: 1, –, 0, 0, 00, 0, 0, func
  - 0010011 I-ALU: 1, I, 1, 0, 00, 0, 0, func
  - 1100011 branch: 0, B, 0, 0, 00, 1, 0, sub
  - 1101111 jal: 1, J, –, 0, 10, 0, 1
  - 1100111 jalr: 1, I, 1, 0, 10, 0, 1, PCTargetSrc=1
  - 0110111 lui: 1, U, 1, 0, 00, 0, 0, passB
- ALU codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 0101 sltu, 0110 xor, 0111 sll, 1000 srl, 1001 sra, 1010 passB.
- ALU function decode:
  - R-type with funct7b5=1: funct3 000 → sub, 101 → sra.
  - I-type funct3 000 is always add (funct7b5 is an immediate bit).
  - I-type srai: funct3 101 with funct7b5=1 → sra.
- Illegal instructions: any other opcode, branch funct3 010/011, or jalr funct3≠000.
  - IllegalD=1 and all D-stage controls forced to NOP (RegWrite, MemWrite, Branch, Jump = 0; all other fields 0).
- Branch condition, registered funct3E: 000 ZeroE, 001 !ZeroE, 100 LtE, 101 !LtE, 110 LtuE, 111 !LtuE.
- PCSrcE = (BranchE & cond) | JumpE.
- FlushE: the D/E register loads the NOP bundle (all zero) at the clock edge instead of the decoded values. FlushM does the same for E/M.
- Priority per register: reset > flush > normal load.
- FlushE and FlushM asserted together: both registers take NOP; M/W still loads the old E/M contents.
- Reset clears every registered output and internal field to 0; PCSrcE therefore reads 0. Reset mid-stream discards all in-flight controls in the same edge.
- No X propagation: unused fields carry defined 0s.

Optional Feature:
- Macro: PIPE_CTRL_MEXT_EN.
- When defined:
  - Opcode 0110011 with funct7=0000001 is decoded as RV32M.
  - Extra output MulDivE (1 bit) and ALUControlE codes: 1011 mul, 1100 mulh, 1101 div, 1110 rem. Other funct3 map to the nearest supported code: mulhsu/mulhu → mulh, divu → div, remu → rem.
  - This feature requires an extra funct7b0D input port.
- When undefined: no extra ports; funct7b0 is ignored and these encodings decode as the base R-type.

Test Plan:
- Reset with opD=0110011 held → after reset release and 1 clock, ALUControlE=0000 (add); RegWriteW=0 until 3 clocks later; all outputs 0 during reset.
- lw (opD=0000011, funct3=010) → ImmSrcD=000; ResultSrcE0=1 next cycle; RegWriteM=1, Funct3M=010 at +2; ResultSrcW=01 at +3.
- Branch tests, opD=1100011 (cond column evaluated with the flag values in parentheses):

  | funct3 | flags | PCSrcE |
  |---|---|---|
  | 001 (bne) | ZeroE=0 | 1 |
  | 001 (bne) | ZeroE=1 | 0 |
  | 110 (bltu) | LtuE=1, LtE=0 | 1 |

- jalr (opD=1100111, funct3=000) → PCSrcE=1 and PCTargetSrcE=1 in E; ResultSrcW=10. Same opcode with funct3=001 → IllegalD=1, all E controls 0.
- FlushE asserted during a sw in Decode → MemWriteM=0 two cycles later. Simultaneous FlushE+FlushM → both registers NOP; W stage keeps the prior M contents.
- srai (opD=0010011, funct3=101, funct7b5=1) → ALUControlE=1001. addi with funct7b5=1 → 0000.
